// File: rtl/intra_pkg.sv
// Shared types and helpers for the luma 4x4 intra prediction/reconstruction path.
package intra_pkg;
  localparam int PIX_W = 8;

  typedef logic        [PIX_W-1:0] pix_t;
  typedef logic signed [PIX_W-1:0] res_t;

  // Same ordering as the encoder's residual index.
  typedef enum logic [2:0] {
    MODE_V   = 3'd0,
    MODE_H   = 3'd1,
    MODE_VL  = 3'd2,
    MODE_VR  = 3'd3,
    MODE_HU  = 3'd4,
    MODE_HD  = 3'd5,
    MODE_DDL = 3'd6,
    MODE_DDR = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRED = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  function automatic pix_t clip255(input logic signed [9:0] s);
    if (s < 0) return '0;
    else if (s > 10'sd255) return 8'd255;
    else return s[7:0];
  endfunction

  function automatic pix_t filt2(input pix_t a, input pix_t b);
    logic [9:0] s;
    s = {2'b00, a} + {2'b00, b} + 10'd1;
    return s[8:1];
  endfunction

  function automatic pix_t filt3(input pix_t a, input pix_t b, input pix_t c);
    logic [9:0] s;
    s = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c} + 10'd2;
    return s[9:2];
  endfunction
endpackage

// File: rtl/intrapred4x4_core.sv
// Combinational 4x4 luma intra predictor for the eight directional modes.
module intrapred4x4_core
  import intra_pkg::*;
(
  input  logic [2:0] mode,
  input  logic [7:0] top  [8],
  input  logic [7:0] left [5],
  output logic [7:0] pred [16]
);
  // Edge strip L,K,J,I,M,A..H: top x sits at 5+x, left y at 3-y, M at 4 for both.
  pix_t w_edge [13];

  function automatic pix_t pt(input pix_t e [13], input int x);
    return e[4'(x + 5)];
  endfunction

  function automatic pix_t pl(input pix_t e [13], input int y);
    return e[4'(3 - y)];
  endfunction

  function automatic pix_t pred_sample(input logic [2:0] m, input pix_t e [13],
                                       input int x, input int y);
    int   z;
    int   d;
    pix_t r;
    r = '0;
    case (mode_e'(m))
      MODE_V: r = pt(e, x);
      MODE_H: r = pl(e, y);
      MODE_VL: begin
        d = x + y / 2;
        if (y % 2 == 0) r = filt2(pt(e, d), pt(e, d + 1));
        else r = filt3(pt(e, d), pt(e, d + 1), pt(e, d + 2));
      end
      MODE_VR: begin
        z = 2 * x - y;
        d = x - y / 2;
        if (z >= 0 && z % 2 == 0) r = filt2(pt(e, d - 1), pt(e, d));
        else if (z > 0) r = filt3(pt(e, d - 2), pt(e, d - 1), pt(e, d));
        else if (z == -1) r = filt3(pl(e, 0), pl(e, -1), pt(e, 0));
        else r = filt3(pl(e, y - 1), pl(e, y - 2), pl(e, y - 3));
      end
      MODE_HU: begin
        z = x + 2 * y;
        d = y + x / 2;
        if (z > 5) r = pl(e, 3);
        else if (z == 5) r = filt3(pl(e, 2), pl(e, 3), pl(e, 3));
        else if (z % 2 == 0) r = filt2(pl(e, d), pl(e, d + 1));
        else r = filt3(pl(e, d), pl(e, d + 1), pl(e, d + 2));
      end
      MODE_HD: begin
        z = 2 * y - x;
        d = y - x / 2;
        if (z >= 0 && z % 2 == 0) r = filt2(pl(e, d - 1), pl(e, d));
        else if (z > 0) r = filt3(pl(e, d - 2), pl(e, d - 1), pl(e, d));
        else if (z == -1) r = filt3(pl(e, 0), pl(e, -1), pt(e, 0));
        else r = filt3(pt(e, x - 1), pt(e, x - 2), pt(e, x - 3));
      end
      MODE_DDL: begin
        if (x == 3 && y == 3) r = filt3(pt(e, 6), pt(e, 7), pt(e, 7));
        else r = filt3(pt(e, x + y), pt(e, x + y + 1), pt(e, x + y + 2));
      end
      MODE_DDR: begin
        if (x > y) r = filt3(pt(e, x - y - 2), pt(e, x - y - 1), pt(e, x - y));
        else if (x < y) r = filt3(pl(e, y - x - 2), pl(e, y - x - 1), pl(e, y - x));
        else r = filt3(pt(e, 0), pl(e, -1), pl(e, 0));
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  genvar gi;
  for (gi = 0; gi < 5; gi++) begin : g_left
    assign w_edge[gi] = left[4-gi];
  end
  for (gi = 0; gi < 8; gi++) begin : g_top
    assign w_edge[5+gi] = top[gi];
  end
  for (gi = 0; gi < 16; gi++) begin : g_pix
    assign pred[gi] = pred_sample(mode, w_edge, gi % 4, gi / 4);
  end
endmodule

// File: rtl/intrarecon_luma4x4.sv
// Luma 4x4 intra reconstruction: captures a block, regenerates its prediction,
// then streams clip(pred + res) out one row per handshake.
module intrarecon_luma4x4
  import intra_pkg::*;
#(
  parameter int BLK_CNT_BITS = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              mode,
  input  logic signed [7:0]       res  [16],
  input  logic [7:0]              top  [8],
  input  logic [7:0]              left [5],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_row [4],
  output logic [1:0]              out_rowidx,
  output logic                    out_last,
  output logic [2:0]              out_mode,
  output logic [BLK_CNT_BITS-1:0] blk_count
);
  state_e                  r_state;
  logic [2:0]              r_mode;
  res_t                    r_res     [16];
  pix_t                    r_top     [8];
  pix_t                    r_left    [5];
  pix_t                    r_pred    [16];
  pix_t                    r_out_row [4];
  logic [1:0]              r_row;
  logic                    r_out_valid;
  logic                    r_in_ready;
  logic                    r_out_last;
  logic [2:0]              r_out_mode;
  logic [BLK_CNT_BITS-1:0] r_blk_cnt;

  pix_t              w_pred     [16];
  logic [1:0]        w_row_nxt;
  pix_t              w_pix      [4];
  logic signed [9:0] w_sum      [4];
  pix_t              w_row_clip [4];

  intrapred4x4_core u_core (
    .mode (r_mode),
    .top  (r_top),
    .left (r_left),
    .pred (w_pred)
  );

  // Row 0 is built straight from the predictor in PRED; later rows from stored pred.
  assign w_row_nxt = (r_state == ST_PRED) ? 2'd0 : r_row + 2'd1;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_col
    assign w_pix[gi]      = (r_state == ST_PRED) ? w_pred[gi] : r_pred[{w_row_nxt, 2'(gi)}];
    assign w_sum[gi]      = {2'b00, w_pix[gi]} +
                            {{2{r_res[{w_row_nxt, 2'(gi)}][7]}}, r_res[{w_row_nxt, 2'(gi)}]};
    assign w_row_clip[gi] = clip255(w_sum[gi]);
    assign out_row[gi]    = r_out_row[gi];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_mode      <= '0;
      r_res       <= '{default: '0};
      r_top       <= '{default: '0};
      r_left      <= '{default: '0};
      r_pred      <= '{default: '0};
      r_out_row   <= '{default: '0};
      r_row       <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_mode  <= '0;
      r_blk_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_mode     <= mode;
            r_out_mode <= mode;
            r_res      <= res;
            r_top      <= top;
            r_left     <= left;
            r_in_ready <= 1'b0;
            r_state    <= ST_PRED;
          end
        end
        ST_PRED: begin
          r_pred      <= w_pred;
          r_out_row   <= w_row_clip;
          r_row       <= 2'd0;
          r_out_valid <= 1'b1;
          r_out_last  <= 1'b0;
          r_state     <= ST_EMIT;
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (r_row == 2'd3) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_blk_cnt   <= r_blk_cnt + 1'b1;
              r_in_ready  <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_row      <= r_row + 2'd1;
              r_out_row  <= w_row_clip;
              r_out_last <= (r_row == 2'd2);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_rowidx = r_row;
  assign out_last   = r_out_last;
  assign out_mode   = r_out_mode;
  assign blk_count  = r_blk_cnt;
endmodule
